// File: rtl/pcm_quantizer_pkg.sv
// Shared types and the round/saturate rule for the PCM quantizer stage.
// Turns a wide signed fixed-point sample into 16-bit signed PCM plus a clip flag.
package pcm_pkg;

    localparam int PCM_W = 16;
    localparam int IN_W  = 65;

    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic signed [IN_W-1:0]  wide_t;

    typedef struct packed {
        logic clip;
        pcm_t pcm;
    } q_res_t;

    localparam logic signed [IN_W:0] R_MAX = 32767;
    localparam logic signed [IN_W:0] R_MIN = -32768;

    // One guard bit above the input keeps the rounding add from overflowing.
    function automatic q_res_t quantize(input wide_t x, input int frac_bits);
        logic signed [IN_W:0] t;
        logic signed [IN_W:0] r;
        int                   shift;
        q_res_t               res;
        shift = frac_bits - 15;
        t = {x[IN_W-1], x} + ((IN_W+1)'(1) << (shift - 1));
        r = t >>> shift;
        if (r > R_MAX) begin
            res.clip = 1'b1;
            res.pcm  = 16'sh7FFF;
        end else if (r < R_MIN) begin
            res.clip = 1'b1;
            res.pcm  = 16'sh8000;
        end else begin
            res.clip = 1'b0;
            res.pcm  = r[PCM_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pcm_quantizer_if.sv
// Input (wide sample) and output (16-bit PCM + channel) valid/ready streams.
// The master drives samples in and consumes PCM out; the slave is the quantizer.
interface pcm_quantizer_if #(
    parameter int CH_W = 1
);
    import pcm_pkg::*;

    wide_t            in_pcm_sample;
    logic             in_pcm_valid;
    logic             in_pcm_ready;
    pcm_t             out_pcm_sample;
    logic [CH_W-1:0]  out_pcm_channel;
    logic             out_pcm_valid;
    logic             out_pcm_ready;

    modport master (
        output in_pcm_sample,
        output in_pcm_valid,
        input  in_pcm_ready,
        input  out_pcm_sample,
        input  out_pcm_channel,
        input  out_pcm_valid,
        output out_pcm_ready
    );

    modport slave (
        input  in_pcm_sample,
        input  in_pcm_valid,
        output in_pcm_ready,
        output out_pcm_sample,
        output out_pcm_channel,
        output out_pcm_valid,
        input  out_pcm_ready
    );

endinterface

// File: rtl/pcm_quantizer_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module pcm_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/pcm_quantizer.sv
// Rounds/saturates wide PCM to 16 bits, buffers it, tags interleaved channels, counts clips.
// Input acceptance is gated by FIFO count plus the in-flight S1 sample so S1 never stalls.
module pcm_quantizer
    import pcm_pkg::*;
#(
    parameter int FRAC_BITS = 32,
    parameter int DEPTH     = 4,
    parameter int CHANNELS  = 2
) (
    input  logic               clk,
    input  logic               reset,
    pcm_quantizer_if.slave     pcm,
    output logic [15:0]        clip_count
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_xfer;
    logic             out_xfer;
    q_res_t           q_p0;

    logic             s1_vld_q, s1_vld_d;
    logic             s1_clip_q, s1_clip_d;
    pcm_t             s1_pcm_q, s1_pcm_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ;
    logic [PCM_W-1:0] head;

    logic [CH_W-1:0]  chan_q, chan_d;
    logic [15:0]      clip_q, clip_d;

    assign occ              = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_vld_q};
    assign pcm.in_pcm_ready = !reset && (occ < (CNT_W+1)'(DEPTH));
    assign in_xfer          = pcm.in_pcm_valid && pcm.in_pcm_ready;
    assign out_xfer         = pcm.out_pcm_valid && pcm.out_pcm_ready;

    assign q_p0 = quantize(pcm.in_pcm_sample, FRAC_BITS);

    always_comb begin
        s1_vld_d  = in_xfer;
        s1_pcm_d  = s1_pcm_q;
        s1_clip_d = s1_clip_q;
        if (in_xfer) begin
            s1_pcm_d  = q_p0.pcm;
            s1_clip_d = q_p0.clip;
        end
    end

    // ---- S1 stage boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_clip_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_clip_q <= s1_clip_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_pcm_q <= s1_pcm_d;
    end

    pcm_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (s1_vld_q),
        .wdata_i (s1_pcm_q),
        .pop_i   (out_xfer),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    always_comb begin
        chan_d = chan_q;
        clip_d = clip_q;
        if (out_xfer) begin
            chan_d = (chan_q == CH_W'(CHANNELS - 1)) ? '0 : chan_q + 1'b1;
        end
        if (s1_vld_q && s1_clip_q && (clip_q != 16'hFFFF)) begin
            clip_d = clip_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_q <= '0;
            clip_q <= '0;
        end else begin
            chan_q <= chan_d;
            clip_q <= clip_d;
        end
    end

    // Head is masked so the sample output reads zero whenever nothing is buffered.
    assign pcm.out_pcm_valid   = (fifo_count != '0);
    assign pcm.out_pcm_sample  = pcm.out_pcm_valid ? pcm_t'(head) : '0;
    assign pcm.out_pcm_channel = chan_q;
    assign clip_count          = clip_q;

endmodule

// File: tb/tb_pcm_quantizer.sv
// Scoreboard bench for pcm_quantizer: arithmetic reference model, decoupled monitor.
module tb_pcm_quantizer;

    localparam int FRAC_BITS = 32;
    localparam int DEPTH     = 4;
    localparam int CHANNELS  = 2;
    localparam int SHIFT     = FRAC_BITS - 15;
    localparam logic signed [65:0] SCALE = 66'sd1 <<< SHIFT;
    localparam logic signed [65:0] HALF  = 66'sd1 <<< (SHIFT - 1);

    logic        clk;
    logic        reset;
    logic [15:0] clip_count;

    pcm_quantizer_if #(.CH_W(1)) bus ();

    pcm_quantizer #(
        .FRAC_BITS (FRAC_BITS),
        .DEPTH     (DEPTH),
        .CHANNELS  (CHANNELS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pcm        (bus),
        .clip_count (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] sb[$];
    logic signed [15:0] lit[$];
    logic signed [64:0] stim[$];
    int                 sidx;
    int                 n_out;
    int                 exp_clip;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-half-up written as floor((x + half) / scale), then clamp.
    function automatic void ref_q(input logic signed [64:0] x, output int v, output bit clip);
        logic signed [65:0] t;
        logic signed [65:0] q;
        t = x;
        t = t + HALF;
        q = t / SCALE;
        if (t < 0 && (q * SCALE) != t) q = q - 1;
        clip = 1'b1;
        if (q > 32767)       v = 32767;
        else if (q < -32768) v = -32768;
        else begin
            v    = int'(q);
            clip = 1'b0;
        end
    endfunction

    function automatic logic signed [64:0] rnd_sample();
        logic [64:0]        raw;
        logic signed [64:0] s;
        longint             k;
        raw = {1'($urandom), $urandom, $urandom};
        case ($urandom_range(0, 3))
            0: s = raw;
            1: s = $signed(raw[33:0]);
            2: begin
                k = longint'($urandom_range(0, 80000)) - 40000;
                s = k * 131072 + 65536;
            end
            default: s = $signed(raw[20:0]);
        endcase
        return s;
    endfunction

    // Monitor: inputs only change #1 after posedge, so at negedge both sides are settled.
    logic               prev_stall;
    logic signed [15:0] prev_sample;
    logic               prev_chan;

    always @(negedge clk) begin
        int                 v;
        bit                 c;
        logic signed [15:0] e;
        if (reset) begin
            sb.delete();
            n_out      = 0;
            exp_clip   = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.in_pcm_valid && bus.in_pcm_ready) begin
                ref_q(bus.in_pcm_sample, v, c);
                sb.push_back(16'(v));
                if (c && exp_clip < 65535) exp_clip++;
            end
            if (prev_stall && bus.out_pcm_valid) begin
                chk("stall_sample", bus.out_pcm_sample, prev_sample);
                chk("stall_chan", bus.out_pcm_channel, prev_chan);
            end
            if (bus.out_pcm_valid && bus.out_pcm_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sample", bus.out_pcm_sample, e);
                    chk("out_chan", bus.out_pcm_channel, n_out % CHANNELS);
                    if (lit.size() != 0) chk("out_literal", bus.out_pcm_sample, lit.pop_front());
                    n_out++;
                end
            end
            prev_stall  = bus.out_pcm_valid && !bus.out_pcm_ready;
            prev_sample = bus.out_pcm_sample;
            prev_chan   = bus.out_pcm_channel;
        end
    end

    // Called #1 after a posedge; offers stim[sidx..] one per cycle for n cycles.
    task automatic drive_cycles(input int n);
        bit acc;
        for (int c = 0; c < n; c++) begin
            if (sidx < stim.size()) begin
                bus.in_pcm_valid  = 1'b1;
                bus.in_pcm_sample = stim[sidx];
            end else begin
                bus.in_pcm_valid = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_pcm_valid && bus.in_pcm_ready;
            @(posedge clk);
            #1;
            if (acc) sidx++;
        end
        bus.in_pcm_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_pcm_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_random(input int n);
        stim.delete();
        sidx = 0;
        for (int i = 0; i < n; i++) stim.push_back(rnd_sample());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset              = 1'b1;
        bus.in_pcm_valid   = 1'b0;
        bus.in_pcm_sample  = '0;
        bus.out_pcm_ready  = 1'b0;
        sidx               = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_pcm_ready, 0);
        chk("rst_out_valid", bus.out_pcm_valid, 0);
        chk("rst_out_sample", bus.out_pcm_sample, 0);
        chk("rst_out_chan", bus.out_pcm_channel, 0);
        chk("rst_clip", clip_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_pcm_ready, 1);
        @(posedge clk);
        #1;

        // Rounding
        bus.out_pcm_ready = 1'b1;
        stim.delete();
        sidx = 0;
        stim.push_back(65'sd1 <<< 31);      lit.push_back(16'sd16384);
        stim.push_back(65'sd1 <<< 16);      lit.push_back(16'sd1);
        stim.push_back(-(65'sd1 <<< 16));   lit.push_back(16'sd0);
        stim.push_back(-65'sd65537);        lit.push_back(-16'sd1);
        drive_cycles(4);
        idle(4);
        chk("round_clip", clip_count, 0);
        chk("round_drained", sb.size(), 0);

        // Saturation
        stim.delete();
        sidx = 0;
        stim.push_back(65'sd1 <<< 32);      lit.push_back(16'sd32767);
        stim.push_back(-(65'sd1 <<< 33));   lit.push_back(-16'sd32768);
        stim.push_back(65'sd1 <<< 40);      lit.push_back(16'sd32767);
        drive_cycles(3);
        idle(4);
        chk("sat_clip", clip_count, 3);
        chk("sat_drained", sb.size(), 0);

        // Latency from empty
        bus.in_pcm_sample = 65'sd5 <<< 17;
        bus.in_pcm_valid  = 1'b1;
        @(negedge clk);
        chk("lat_accept", bus.in_pcm_ready, 1);
        @(posedge clk);
        #1;
        bus.in_pcm_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", bus.out_pcm_valid, 0);
        @(negedge clk);
        chk("lat_n2_valid", bus.out_pcm_valid, 1);
        @(posedge clk);
        #1;
        idle(2);

        // Backpressure
        load_random(10);
        bus.out_pcm_ready = 1'b0;
        drive_cycles(12);
        chk("bp_accepted", sidx, DEPTH);
        chk("bp_in_ready", bus.in_pcm_ready, 0);
        bus.out_pcm_ready = 1'b1;
        drive_cycles(20);
        chk("bp_all_accepted", sidx, 10);
        idle(4);
        chk("bp_drained", sb.size(), 0);

        // Streaming
        load_random(100);
        n0 = n_out;
        drive_cycles(102);
        chk("stream_accepted", sidx, 100);
        chk("stream_outputs", n_out - n0, 100);
        idle(3);
        chk("stream_clip", clip_count, exp_clip);

        // Simultaneous push/pop at full
        load_random(6);
        bus.out_pcm_ready = 1'b0;
        drive_cycles(8);
        chk("full_accepted", sidx, DEPTH);
        chk("full_in_ready", bus.in_pcm_ready, 0);
        bus.out_pcm_ready = 1'b1;
        drive_cycles(1);
        bus.out_pcm_ready = 1'b0;
        drive_cycles(3);
        chk("full_refill", sidx, DEPTH + 1);
        chk("full_in_ready2", bus.in_pcm_ready, 0);
        bus.out_pcm_ready = 1'b1;
        drive_cycles(10);
        chk("full_all_accepted", sidx, 6);
        idle(4);
        chk("full_drained", sb.size(), 0);

        // Reset mid-stream
        load_random(3);
        bus.out_pcm_ready = 1'b0;
        drive_cycles(5);
        chk("mrst_buffered", sidx, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", bus.in_pcm_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", bus.out_pcm_valid, 0);
        chk("mrst_clip", clip_count, 0);
        chk("mrst_chan", bus.out_pcm_channel, 0);
        @(posedge clk);
        #1;
        bus.out_pcm_ready = 1'b1;
        load_random(3);
        n0 = n_out;
        drive_cycles(6);
        idle(3);
        chk("mrst_outputs", n_out - n0, 3);
        chk("mrst_drained", sb.size(), 0);
        chk("mrst_clip2", clip_count, exp_clip);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
